// File: rtl/vga_timing_decoder_if.sv
// Video sync/recovery bundle between a VGA timing source and the decoder.
// master drives pixel_clk/hs/vs/blank; slave returns position, lock and errors.
interface vga_timing_decoder_if;
  logic       pixel_clk;
  logic       hs;
  logic       vs;
  logic       blank;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       de;
  logic       locked;
  logic       frame_start;
  logic       sync_err;
  logic       blank_err;
  logic [7:0] err_count;

  modport master (
    output pixel_clk, hs, vs, blank,
    input  DrawX, DrawY, de, locked,
    input  frame_start, sync_err, blank_err, err_count
  );

  modport slave (
    input  pixel_clk, hs, vs, blank,
    output DrawX, DrawY, de, locked,
    output frame_start, sync_err, blank_err, err_count
  );
endinterface

// File: rtl/vga_timing_decoder.sv
// Recovers pixel position and timing lock from VGA pixel_clk/hs/vs/blank.
// Ports: Clk, Reset_n (async, active-low); vif.slave sync in, status out.
module vga_timing_decoder #(
  parameter int H_TOTAL      = 800,
  parameter int V_TOTAL      = 525,
  parameter int H_SYNC_START = 656,
  parameter int V_SYNC_START = 490,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  vga_timing_decoder_if.slave  vif
);

  typedef enum logic [1:0] {
    SEARCH,
    ALIGN,
    VERIFY,
    LOCKED
  } state_e;

  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_SYNC = 10'(H_SYNC_START);
  localparam logic [9:0]  H_SLIP = 10'(H_SYNC_START + 1);
  localparam logic [9:0]  V_SYNC = 10'(V_SYNC_START);
  localparam logic [9:0]  H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [10:0] H_PER  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_TMO  = 11'(H_TOTAL + 7);
  localparam logic [9:0]  V_PER  = 10'(V_TOTAL);

  state_e      state_q, state_d;
  logic        run_q, run_d;
  logic        pclk_q, pclk_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [9:0]  hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic [10:0] hper_q, hper_d;
  logic [9:0]  vper_q, vper_d;
  logic        sync_p_q, sync_p_d;
  logic        blank_p_q, blank_p_d;
  logic        fs_p_q, fs_p_d;
  logic [9:0]  draw_x_q, draw_x_d;
  logic [9:0]  draw_y_q, draw_y_d;
  logic        de_q, de_d;
  logic        locked_q, locked_d;
  logic        fs_q, fs_d;
  logic        sync_err_q, sync_err_d;
  logic        blank_err_q, blank_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic        tick;
  logic        hs_fall;
  logic        vs_fall;
  logic        h_wrap;
  logic        in_active;
  logic        timeout;
  logic        verify_bad;
  logic        lock_bad;
  logic        is_locked;
  logic [8:0]  err_sum;

  // run_q holds off tick detection on the cycle reset is released
  assign tick      = run_q & ~pclk_q & vif.pixel_clk;
  assign hs_fall   = hs_q & ~vif.hs;
  assign vs_fall   = vs_q & ~vif.vs;
  assign h_wrap    = (hcount_q == H_LAST);
  assign in_active = (hcount_q < H_ACT) && (vcount_q < V_ACT);
  assign timeout   = !hs_fall && (hper_q == H_TMO);
  assign is_locked = (state_q == LOCKED);

  assign verify_bad = (hs_fall && hper_q != H_PER)
                   || (vs_fall && vper_q != V_PER)
                   || timeout;

  assign lock_bad = (hs_fall && hcount_q != H_SYNC)
                 || (vs_fall && vcount_q != V_SYNC)
                 || timeout;

  always_comb begin
    state_d   = state_q;
    run_d     = 1'b1;
    pclk_d    = vif.pixel_clk;
    hs_d      = hs_q;
    vs_d      = vs_q;
    hcount_d  = hcount_q;
    vcount_d  = vcount_q;
    hper_d    = hper_q;
    vper_d    = vper_q;
    sync_p_d  = 1'b0;
    blank_p_d = 1'b0;
    fs_p_d    = 1'b0;
    if (tick) begin
      hs_d = vif.hs;
      vs_d = vif.vs;
      hcount_d = h_wrap ? 10'd0 : hcount_q + 10'd1;
      if (h_wrap) begin
        vcount_d = (vcount_q == V_LAST) ? 10'd0
                                        : vcount_q + 10'd1;
      end
      if (hs_fall) begin
        hcount_d = H_SLIP;
      end
      if (vs_fall) begin
        vcount_d = V_SYNC;
      end
      if (hs_fall) begin
        hper_d = '0;
      end else if (hper_q != '1) begin
        hper_d = hper_q + 11'd1;
      end
      if (vs_fall) begin
        vper_d = '0;
      end else if (h_wrap && vper_q != '1) begin
        vper_d = vper_q + 10'd1;
      end
      unique case (state_q)
        SEARCH: begin
          if (vs_fall) begin
            state_d = ALIGN;
          end
        end
        ALIGN: begin
          if (hs_fall) begin
            state_d = VERIFY;
            hper_d  = '0;
            vper_d  = '0;
          end
        end
        VERIFY: begin
          if (verify_bad) begin
            state_d = SEARCH;
          end else if (vs_fall) begin
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (lock_bad) begin
            state_d  = SEARCH;
            sync_p_d = 1'b1;
          end
          blank_p_d = (vif.blank != in_active);
          fs_p_d    = (hcount_q == 10'd0)
                   && (vcount_q == 10'd0);
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  assign err_sum = {1'b0, err_cnt_q}
                 + {8'd0, sync_p_q}
                 + {8'd0, blank_p_q};

  always_comb begin
    draw_x_d    = is_locked ? hcount_q : 10'd0;
    draw_y_d    = is_locked ? vcount_q : 10'd0;
    de_d        = is_locked
               && (hcount_q < H_ACT)
               && (vcount_q < V_ACT);
    locked_d    = is_locked;
    fs_d        = fs_p_q;
    sync_err_d  = sync_p_q;
    blank_err_d = blank_p_q;
    err_cnt_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= SEARCH;
      run_q       <= 1'b0;
      pclk_q      <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      hcount_q    <= '0;
      vcount_q    <= '0;
      hper_q      <= '0;
      vper_q      <= '0;
      sync_p_q    <= 1'b0;
      blank_p_q   <= 1'b0;
      fs_p_q      <= 1'b0;
      draw_x_q    <= '0;
      draw_y_q    <= '0;
      de_q        <= 1'b0;
      locked_q    <= 1'b0;
      fs_q        <= 1'b0;
      sync_err_q  <= 1'b0;
      blank_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      pclk_q      <= pclk_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      hper_q      <= hper_d;
      vper_q      <= vper_d;
      sync_p_q    <= sync_p_d;
      blank_p_q   <= blank_p_d;
      fs_p_q      <= fs_p_d;
      draw_x_q    <= draw_x_d;
      draw_y_q    <= draw_y_d;
      de_q        <= de_d;
      locked_q    <= locked_d;
      fs_q        <= fs_d;
      sync_err_q  <= sync_err_d;
      blank_err_q <= blank_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign vif.DrawX       = draw_x_q;
  assign vif.DrawY       = draw_y_q;
  assign vif.de          = de_q;
  assign vif.locked      = locked_q;
  assign vif.frame_start = fs_q;
  assign vif.sync_err    = sync_err_q;
  assign vif.blank_err   = blank_err_q;
  assign vif.err_count   = err_cnt_q;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench for vga_timing_decoder on a shrunken 20x12 raster.
// Drives a small VGA controller model and checks lock, position and errors.
module tb_vga_timing_decoder;

  localparam int HT  = 20;
  localparam int VT  = 12;
  localparam int HSS = 15;
  localparam int VSS = 9;
  localparam int HA  = 12;
  localparam int VA  = 8;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;

  vga_timing_decoder_if vif ();

  vga_timing_decoder #(
    .H_TOTAL      (HT),
    .V_TOTAL      (VT),
    .H_SYNC_START (HSS),
    .V_SYNC_START (VSS),
    .H_ACTIVE     (HA),
    .V_ACTIVE     (VA)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .vif     (vif)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  int hc = 0;
  int vc = 0;
  int line_len = HT;
  bit hs_hold = 1'b0;
  bit blk_flip = 1'b0;
  bit track = 1'b0;

  int tick_no = 0;
  int serr_tick = -1;
  int n_serr = 0;
  int n_berr = 0;
  int n_fs = 0;
  int bad = 0;
  int t0 = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One pixel tick: drive sample for (hc,vc), then advance the raster.
  // Returns #1 after the output register has captured this tick.
  task automatic step();
    logic h, v, b;
    int phc, pvc;
    phc = hc;
    pvc = vc;
    h = !(hc >= HSS && hc < HSS + 2) || hs_hold;
    v = (vc != VSS);
    b = (hc < HA && vc < VA) ^ blk_flip;
    @(negedge Clk);
    vif.pixel_clk = 1'b1;
    vif.hs = h;
    vif.vs = v;
    vif.blank = b;
    @(negedge Clk);
    vif.pixel_clk = 1'b0;
    hc++;
    if (hc >= line_len) begin
      hc = 0;
      line_len = HT;
      vc = (vc == VT - 1) ? 0 : vc + 1;
    end
    @(posedge Clk);
    #1;
    tick_no++;
    if (vif.sync_err === 1'b1) begin
      n_serr++;
      serr_tick = tick_no;
    end
    if (vif.blank_err === 1'b1) n_berr++;
    if (vif.frame_start === 1'b1) n_fs++;
    if (track) begin
      if (vif.DrawX !== 10'(hc)) bad++;
      if (vif.DrawY !== 10'(vc)) bad++;
      if (vif.de !== (hc < HA && vc < VA)) bad++;
      if (vif.locked !== 1'b1) bad++;
      if (vif.frame_start !== (phc == 0 && pvc == 0)) bad++;
    end
  endtask

  task automatic run_to(input int thc, input int tvc);
    for (int i = 0; i < 2 * HT * VT; i++) begin
      if (hc == thc && vc == tvc) break;
      step();
    end
  endtask

  task automatic frames(input int n);
    repeat (n * HT * VT) step();
  endtask

  task automatic clr();
    n_serr = 0;
    n_berr = 0;
    n_fs = 0;
    bad = 0;
    serr_tick = -1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    vif.pixel_clk = 1'b0;
    vif.hs = 1'b1;
    vif.vs = 1'b1;
    vif.blank = 1'b0;
    hc = 0;
    vc = 0;
    line_len = HT;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  task automatic lock_up();
    do_reset();
    frames(2);
    clr();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vif.pixel_clk = 1'b0;
    vif.hs = 1'b1;
    vif.vs = 1'b1;
    vif.blank = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_x", 32'(vif.DrawX), 0);
    chk("rst_y", 32'(vif.DrawY), 0);
    chk("rst_de", 32'(vif.de), 0);
    chk("rst_lock", 32'(vif.locked), 0);
    chk("rst_fs", 32'(vif.frame_start), 0);
    chk("rst_serr", 32'(vif.sync_err), 0);
    chk("rst_berr", 32'(vif.blank_err), 0);
    chk("rst_errc", 32'(vif.err_count), 0);

    // acquisition over clean frames, then full tracking of frame 3
    do_reset();
    frames(1);
    chk("lock_f1", 32'(vif.locked), 0);
    frames(1);
    chk("lock_f3", 32'(vif.locked), 1);
    clr();
    track = 1'b1;
    frames(1);
    track = 1'b0;
    chk("track_bad", 32'(bad), 0);
    chk("fs_count", 32'(n_fs), 1);
    chk("trk_serr", 32'(n_serr), 0);
    chk("trk_errc", 32'(vif.err_count), 0);

    // single blank error keeps lock
    clr();
    run_to(5, 5);
    blk_flip = 1'b1;
    step();
    blk_flip = 1'b0;
    run_to(0, 0);
    chk("b_berr", 32'(n_berr), 1);
    chk("b_serr", 32'(n_serr), 0);
    chk("b_lock", 32'(vif.locked), 1);
    chk("b_errc", 32'(vif.err_count), 1);

    // one short line in vertical blanking
    lock_up();
    run_to(0, 10);
    line_len = HT - 1;
    run_to(0, 0);
    chk("s_serr", 32'(n_serr), 1);
    chk("s_berr", 32'(n_berr), 0);
    chk("s_lock", 32'(vif.locked), 0);
    chk("s_errc", 32'(vif.err_count), 1);
    frames(1);
    chk("s_relock0", 32'(vif.locked), 0);
    frames(1);
    chk("s_relock1", 32'(vif.locked), 1);
    chk("s_errc2", 32'(vif.err_count), 1);

    // missing hs edges: timeout at HT+8 ticks after last edge
    lock_up();
    run_to(HSS, 0);
    step();
    t0 = tick_no;
    hs_hold = 1'b1;
    repeat (HT + 10) step();
    hs_hold = 1'b0;
    chk("t_serr", 32'(n_serr), 1);
    chk("t_when", 32'(serr_tick - t0), 32'(HT + 8));
    chk("t_lock", 32'(vif.locked), 0);
    chk("t_errc", 32'(vif.err_count), 1);

    // asynchronous reset mid-frame
    lock_up();
    run_to(3, 5);
    chk("r_pre_y", 32'(vif.DrawY), 5);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("r_x", 32'(vif.DrawX), 0);
    chk("r_y", 32'(vif.DrawY), 0);
    chk("r_lock", 32'(vif.locked), 0);
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    run_to(0, 0);
    chk("r_lock_a", 32'(vif.locked), 0);
    run_to(0, VSS);
    chk("r_lock_b", 32'(vif.locked), 0);
    step();
    chk("r_lock_c", 32'(vif.locked), 1);

    // error counter saturation
    lock_up();
    blk_flip = 1'b1;
    repeat (254) step();
    chk("e_254", 32'(vif.err_count), 254);
    repeat (46) step();
    blk_flip = 1'b0;
    chk("e_nberr", 32'(n_berr), 300);
    chk("e_sat", 32'(vif.err_count), 255);
    chk("e_lock", 32'(vif.locked), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
